gmii_rx_rgb_extract: RTL and testbench



---
 rtl/gmii_rx_rgb_extract_pkg.sv | 44 ++++
 rtl/gmii_rx_rgb_extract_if.sv | 32 +++
 rtl/gmii_rx_rgb_extract.sv | 253 +++++++++++++++++++++++++
 tb/tb_gmii_rx_rgb_extract.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_rx_rgb_extract_pkg.sv
// ---------------------------------------------------------------------------
// gmii_rx_pkg
// Shared types and constants for the GMII receive RGB extractor: parser
// state encoding, preamble/SFD bytes, the header field values checked on
// every frame, the byte offsets of those fields (counted from the first byte
// after SFD), and a helper that converts a pixel count into a payload byte
// count.
// ---------------------------------------------------------------------------
package gmii_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_HEADER,
      ST_APP_HDR,
      ST_PAYLOAD,
      ST_DROP
   } state_t;

   localparam logic [7:0]  C_PREAMBLE     = 8'h55;
   localparam logic [7:0]  C_SFD          = 8'hD5;
   localparam logic [15:0] C_ETHERTYPE_IP = 16'h0800;
   localparam logic [7:0]  C_IP_VER_IHL   = 8'h45;
   localparam logic [7:0]  C_IP_PROTO_UDP = 8'h11;

   // Byte offsets relative to the first byte after SFD.
   localparam logic [5:0] OFS_MAC_LAST  = 6'd5;
   localparam logic [5:0] OFS_ETYPE     = 6'd12;
   localparam logic [5:0] OFS_IP_VER    = 6'd14;
   localparam logic [5:0] OFS_IP_PROTO  = 6'd23;
   localparam logic [5:0] OFS_UDP_DPORT = 6'd36;
   localparam logic [5:0] OFS_PIX_CNT   = 6'd42;
   localparam logic [5:0] OFS_FLAGS     = 6'd44;
   localparam logic [5:0] OFS_PAYLOAD   = 6'd45;

   // Three bytes per pixel, done as shift-and-add in 18 bits so the largest
   // 16-bit pixel count cannot overflow.
   function automatic logic [17:0] pix_to_bytes(input logic [15:0] pix);
      logic [17:0] p18;
      p18 = {2'b00, pix};
      return (p18 << 1) + p18;
   endfunction

endpackage

// File: rtl/gmii_rx_rgb_extract_if.sv
// ---------------------------------------------------------------------------
// gmii_rx_rgb_extract_if
// Bundles the GMII receive pins and the write stream toward the RX
// clock-change buffer.
//   i_rx_dv / i_rx_er / i_rxd : GMII receive valid, error, byte
//   o_write_valid / o_rgb_data: payload byte stream
//   o_sof                     : first payload byte of an image frame
//   o_data_length             : pixel count of the last accepted packet
//   o_pkt_drop                : one-cycle pulse on reject/abort
// slave  = the parser (consumes GMII, drives the stream)
// master = the PHY/buffer side (drives GMII, observes the stream)
// ---------------------------------------------------------------------------
interface gmii_rx_rgb_extract_if;
   logic        i_rx_dv;
   logic        i_rx_er;
   logic [7:0]  i_rxd;
   logic        o_write_valid;
   logic [7:0]  o_rgb_data;
   logic        o_sof;
   logic [15:0] o_data_length;
   logic        o_pkt_drop;

   modport slave (
      input  i_rx_dv, i_rx_er, i_rxd,
      output o_write_valid, o_rgb_data, o_sof, o_data_length, o_pkt_drop
   );

   modport master (
      output i_rx_dv, i_rx_er, i_rxd,
      input  o_write_valid, o_rgb_data, o_sof, o_data_length, o_pkt_drop
   );
endinterface

// File: rtl/gmii_rx_rgb_extract.sv
// ---------------------------------------------------------------------------
// gmii_rx_rgb_extract
// GMII receive parser on the 125 MHz RX clock. Strips preamble/SFD and the
// Ethernet/IPv4/UDP headers, accepts only IPv4/UDP packets to P_UDP_PORT,
// decodes the 3-byte application header (pixel count, flags) and streams the
// RGB payload bytes with start-of-frame and pixel-count sideband.
//
// Ports:
//   i_rx_clk : GMII receive clock
//   i_rst    : synchronous active-high reset
//   bus      : gmii_rx_rgb_extract_if.slave (GMII in, write stream out)
//
// Parameters:
//   P_UDP_PORT   : accepted UDP destination port
//   P_MAX_PIXELS : largest accepted pixel count
//   P_LOCAL_MAC  : local MAC address, only checked with RX_MAC_FILTER_EN
//
// Build option:
//   RX_MAC_FILTER_EN : when defined, destination MAC must be P_LOCAL_MAC or
//                      broadcast; otherwise the MAC bytes are skipped.
//
// All outputs are registered; a payload byte sampled at cycle t appears on
// the stream at t+1.
// ---------------------------------------------------------------------------
module gmii_rx_rgb_extract
   import gmii_rx_pkg::*;
#(
   parameter logic [15:0] P_UDP_PORT   = 16'd5000,
   parameter logic [15:0] P_MAX_PIXELS = 16'd1024,
   parameter logic [47:0] P_LOCAL_MAC  = 48'h00_0A_35_00_00_01
) (
   input  logic                    i_rx_clk,
   input  logic                    i_rst,
   gmii_rx_rgb_extract_if.slave    bus
);

   state_t      state_q,       state_d;
   logic [5:0]  cnt_q,         cnt_d;          // header byte index n
   logic [17:0] rem_q,         rem_d;          // payload bytes still expected
   logic [15:0] pix_q,         pix_d;          // pixel count being assembled
   logic        sof_pend_q,    sof_pend_d;     // SOF flag waiting for byte 0
   logic        dv_prev_q,     dv_prev_d;      // i_rx_dv one cycle ago

   logic        write_valid_q, write_valid_d;
   logic [7:0]  rgb_data_q,    rgb_data_d;
   logic        sof_q,         sof_d;
   logic [15:0] data_length_q, data_length_d;
   logic        pkt_drop_q,    pkt_drop_d;

   logic        hdr_fail;
   logic [15:0] pix_now;

`ifdef RX_MAC_FILTER_EN
   logic        mac_local_ok_q, mac_local_ok_d;
   logic        mac_bcast_ok_q, mac_bcast_ok_d;
   logic [7:0]  local_mac_byte;

   // Destination MAC arrives most-significant byte first.
   always_comb begin
      local_mac_byte = 8'h00;
      case (cnt_q[2:0])
         3'd0:    local_mac_byte = P_LOCAL_MAC[47:40];
         3'd1:    local_mac_byte = P_LOCAL_MAC[39:32];
         3'd2:    local_mac_byte = P_LOCAL_MAC[31:24];
         3'd3:    local_mac_byte = P_LOCAL_MAC[23:16];
         3'd4:    local_mac_byte = P_LOCAL_MAC[15:8];
         3'd5:    local_mac_byte = P_LOCAL_MAC[7:0];
         default: local_mac_byte = 8'h00;
      endcase
   end
`else
   // The local MAC is only meaningful with the filter built in.
   logic unused_local_mac;
   assign unused_local_mac = ^P_LOCAL_MAC;
`endif

   assign pix_now = {pix_q[15:8], bus.i_rxd};

   // Field comparators for the fixed Ethernet/IPv4/UDP header.
   always_comb begin
      hdr_fail = 1'b0;
      case (cnt_q)
         OFS_ETYPE:            hdr_fail = (bus.i_rxd != C_ETHERTYPE_IP[15:8]);
         OFS_ETYPE + 6'd1:     hdr_fail = (bus.i_rxd != C_ETHERTYPE_IP[7:0]);
         OFS_IP_VER:           hdr_fail = (bus.i_rxd != C_IP_VER_IHL);
         OFS_IP_PROTO:         hdr_fail = (bus.i_rxd != C_IP_PROTO_UDP);
         OFS_UDP_DPORT:        hdr_fail = (bus.i_rxd != P_UDP_PORT[15:8]);
         OFS_UDP_DPORT + 6'd1: hdr_fail = (bus.i_rxd != P_UDP_PORT[7:0]);
`ifdef RX_MAC_FILTER_EN
         OFS_MAC_LAST:         hdr_fail = !((mac_local_ok_q && bus.i_rxd == local_mac_byte) ||
                                            (mac_bcast_ok_q && bus.i_rxd == 8'hFF));
`endif
         default:              hdr_fail = 1'b0;
      endcase
   end

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rem_d         = rem_q;
      pix_d         = pix_q;
      sof_pend_d    = sof_pend_q;
      dv_prev_d     = bus.i_rx_dv;
      write_valid_d = 1'b0;
      rgb_data_d    = rgb_data_q;
      sof_d         = 1'b0;
      data_length_d = data_length_q;
      pkt_drop_d    = 1'b0;
`ifdef RX_MAC_FILTER_EN
      mac_local_ok_d = mac_local_ok_q;
      mac_bcast_ok_d = mac_bcast_ok_q;
`endif

      if (!bus.i_rx_dv) begin
         // End of carrier; an unfinished packet counts as aborted.
         state_d = ST_IDLE;
         if (state_q == ST_HEADER || state_q == ST_APP_HDR || state_q == ST_PAYLOAD)
            pkt_drop_d = 1'b1;
      end else if (bus.i_rx_er && state_q != ST_IDLE && state_q != ST_DROP) begin
         // Errored byte is never emitted. A frame already in DROP has been
         // reported once and is not reported again.
         state_d    = ST_DROP;
         pkt_drop_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Only a rising i_rx_dv starts a frame; joining mid-frame
               // (e.g. after reset) parks in DROP until the carrier ends.
               if (!dv_prev_q && !bus.i_rx_er && bus.i_rxd == C_PREAMBLE)
                  state_d = ST_PREAMBLE;
               else
                  state_d = ST_DROP;
            end

            ST_PREAMBLE: begin
               if (bus.i_rxd == C_SFD) begin
                  state_d = ST_HEADER;
                  cnt_d   = '0;
               end else if (bus.i_rxd != C_PREAMBLE) begin
                  state_d = ST_DROP;
               end
            end

            ST_HEADER: begin
               cnt_d = cnt_q + 6'd1;
`ifdef RX_MAC_FILTER_EN
               if (cnt_q <= OFS_MAC_LAST) begin
                  mac_local_ok_d = ((cnt_q == '0) || mac_local_ok_q) &&
                                   (bus.i_rxd == local_mac_byte);
                  mac_bcast_ok_d = ((cnt_q == '0) || mac_bcast_ok_q) &&
                                   (bus.i_rxd == 8'hFF);
               end
`endif
               if (hdr_fail) begin
                  state_d    = ST_DROP;
                  pkt_drop_d = 1'b1;
               end else if (cnt_q == OFS_PIX_CNT - 6'd1) begin
                  state_d = ST_APP_HDR;
               end
            end

            ST_APP_HDR: begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == OFS_PIX_CNT) begin
                  pix_d[15:8] = bus.i_rxd;
               end else if (cnt_q == OFS_PIX_CNT + 6'd1) begin
                  pix_d[7:0] = bus.i_rxd;
                  if (pix_now == 16'd0 || pix_now > P_MAX_PIXELS) begin
                     state_d    = ST_DROP;
                     pkt_drop_d = 1'b1;
                  end
               end else if (cnt_q == OFS_FLAGS) begin
                  // Length is published here, one cycle ahead of the
                  // first payload valid, and held for the whole burst.
                  data_length_d = pix_q;
                  sof_pend_d    = bus.i_rxd[0];
                  rem_d         = pix_to_bytes(pix_q);
                  cnt_d         = OFS_PAYLOAD;
                  state_d       = ST_PAYLOAD;
               end
            end

            ST_PAYLOAD: begin
               write_valid_d = 1'b1;
               rgb_data_d    = bus.i_rxd;
               sof_d         = sof_pend_q;
               sof_pend_d    = 1'b0;
               rem_d         = rem_q - 18'd1;
               // Remaining bytes (FCS, padding) are discarded silently.
               if (rem_q == 18'd1)
                  state_d = ST_DROP;
            end

            ST_DROP: begin
               state_d = ST_DROP;
            end

            default: begin
               state_d = ST_DROP;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge value of every other flop.
   always_ff @(posedge i_rx_clk) begin
      if (i_rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         rem_q         <= '0;
         pix_q         <= '0;
         sof_pend_q    <= 1'b0;
         // Assume the carrier was already up so a frame in flight at reset
         // release is not mistaken for a new one.
         dv_prev_q     <= 1'b1;
         write_valid_q <= 1'b0;
         rgb_data_q    <= '0;
         sof_q         <= 1'b0;
         data_length_q <= '0;
         pkt_drop_q    <= 1'b0;
`ifdef RX_MAC_FILTER_EN
         mac_local_ok_q <= 1'b0;
         mac_bcast_ok_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rem_q         <= rem_d;
         pix_q         <= pix_d;
         sof_pend_q    <= sof_pend_d;
         dv_prev_q     <= dv_prev_d;
         write_valid_q <= write_valid_d;
         rgb_data_q    <= rgb_data_d;
         sof_q         <= sof_d;
         data_length_q <= data_length_d;
         pkt_drop_q    <= pkt_drop_d;
`ifdef RX_MAC_FILTER_EN
         mac_local_ok_q <= mac_local_ok_d;
         mac_bcast_ok_q <= mac_bcast_ok_d;
`endif
      end
   end

   assign bus.o_write_valid = write_valid_q;
   assign bus.o_rgb_data    = rgb_data_q;
   assign bus.o_sof         = sof_q;
   assign bus.o_data_length = data_length_q;
   assign bus.o_pkt_drop    = pkt_drop_q;

endmodule

// File: tb/tb_gmii_rx_rgb_extract.sv
// ---------------------------------------------------------------------------
// tb_gmii_rx_rgb_extract
// Directed bench for gmii_rx_rgb_extract: builds Ethernet/IPv4/UDP frames
// byte by byte, drives them on GMII and checks the write stream, SOF,
// data length and drop pulse against hand-computed values.
// Honors RX_MAC_FILTER_EN to select the MAC-filter scenarios.
// ---------------------------------------------------------------------------
module tb_gmii_rx_rgb_extract;

   logic i_rx_clk = 1'b0;
   logic i_rst    = 1'b1;

   gmii_rx_rgb_extract_if bus();

   gmii_rx_rgb_extract #(
      .P_UDP_PORT   (16'd5000),
      .P_MAX_PIXELS (16'd1024),
      .P_LOCAL_MAC  (48'h00_0A_35_00_00_01)
   ) dut (
      .i_rx_clk (i_rx_clk),
      .i_rst    (i_rst),
      .bus      (bus)
   );

   always #4 i_rx_clk = ~i_rx_clk;

   int cyc = 0;
   always @(posedge i_rx_clk) cyc <= cyc + 1;

   // Stream monitor, sampled on the falling edge.
   int          total_valid = 0;
   int          total_sof   = 0;
   int          total_drop  = 0;
   int          drop_cyc    = -1;
   logic [7:0]  sof_byte    = 8'h00;
   logic [7:0]  cap [0:1023];
   logic        prev_valid  = 1'b0;
   logic [15:0] dl_prev     = 16'h0;
   logic [15:0] dl_before   = 16'h0;

   always @(negedge i_rx_clk) begin
      if (bus.o_write_valid) begin
         if (!prev_valid) dl_before = dl_prev;
         cap[total_valid % 1024] = bus.o_rgb_data;
         total_valid++;
         if (bus.o_sof) begin
            total_sof++;
            sof_byte = bus.o_rgb_data;
         end
      end
      if (bus.o_pkt_drop) begin
         total_drop++;
         drop_cyc = cyc;
      end
      prev_valid = bus.o_write_valid;
      dl_prev    = bus.o_data_length;
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame construction
   logic [7:0] frame [0:199];
   int         frame_len;
   int         n37_cyc;

   task automatic build(input logic [47:0] mac, input logic [15:0] port,
                        input logic [15:0] pix, input logic [7:0] flags, input int npay);
      for (int i = 0; i < 200; i++) frame[i] = 8'h00;
      for (int i = 0; i < 6; i++)  frame[i] = mac[8*(5-i) +: 8];
      for (int i = 6; i < 12; i++) frame[i] = 8'h10 + 8'(i);
      frame[12] = 8'h08; frame[13] = 8'h00;
      frame[14] = 8'h45;
      frame[23] = 8'h11;
      frame[36] = port[15:8]; frame[37] = port[7:0];
      frame[42] = pix[15:8];  frame[43] = pix[7:0];
      frame[44] = flags;
      for (int i = 0; i < npay; i++) frame[45+i] = 8'(i + 1);
      for (int i = 0; i < 4; i++) frame[45+npay+i] = 8'hA5;
      frame_len = 45 + npay + 4;
   endtask

   // stop_at / er_at / rst_at are byte indices n, -1 for none.
   task automatic send(input int stop_at, input int er_at, input int rst_at);
      for (int i = 0; i < 8; i++) begin
         @(negedge i_rx_clk);
         bus.i_rx_dv = 1'b1;
         bus.i_rx_er = 1'b0;
         bus.i_rxd   = (i == 7) ? 8'hD5 : 8'h55;
      end
      for (int i = 0; i < frame_len; i++) begin
         if (i == stop_at) break;
         @(negedge i_rx_clk);
         bus.i_rxd   = frame[i];
         bus.i_rx_er = (i == er_at);
         i_rst       = (i == rst_at);
         if (i == 37) n37_cyc = cyc;
      end
      @(negedge i_rx_clk);
      bus.i_rx_dv = 1'b0;
      bus.i_rx_er = 1'b0;
      bus.i_rxd   = 8'h00;
      i_rst       = 1'b0;
      repeat (6) @(negedge i_rx_clk);
   endtask

   localparam logic [47:0] MAC_LOCAL = 48'h00_0A_35_00_00_01;

   int bv, bd, bs;

   initial begin
      bus.i_rx_dv = 1'b0;
      bus.i_rx_er = 1'b0;
      bus.i_rxd   = 8'h00;

      // Reset state
      repeat (3) @(negedge i_rx_clk);
      check("rst_valid", 32'(bus.o_write_valid), 32'd0);
      check("rst_sof",   32'(bus.o_sof),         32'd0);
      check("rst_data",  32'(bus.o_rgb_data),    32'd0);
      check("rst_len",   32'(bus.o_data_length), 32'd0);
      check("rst_drop",  32'(bus.o_pkt_drop),    32'd0);
      i_rst = 1'b0;
      repeat (3) @(negedge i_rx_clk);

      // Valid frame: port 5000, 4 pixels, SOF flag, bytes 01..0C
      build(MAC_LOCAL, 16'd5000, 16'd4, 8'h01, 12);
      bv = total_valid; bd = total_drop; bs = total_sof;
      send(-1, -1, -1);
      check("ok_len_before", 32'(dl_before), 32'd4);
      check("ok_nvalid", 32'(total_valid - bv), 32'd12);
      for (int i = 0; i < 12; i++)
         check($sformatf("ok_byte%0d", i), 32'(cap[(bv + i) % 1024]), 32'(i + 1));
      check("ok_nsof",   32'(total_sof - bs), 32'd1);
      check("ok_sofbyte", 32'(sof_byte), 32'h01);
      check("ok_ndrop",  32'(total_drop - bd), 32'd0);

      // Wrong UDP port: drop pulse the cycle after n=37
      build(MAC_LOCAL, 16'd5001, 16'd4, 8'h01, 12);
      bv = total_valid; bd = total_drop;
      send(-1, -1, -1);
      check("port_nvalid", 32'(total_valid - bv), 32'd0);
      check("port_ndrop",  32'(total_drop - bd),  32'd1);
      check("port_dropcyc", 32'(drop_cyc), 32'(n37_cyc + 1));

      // Pixel count above the limit
      build(MAC_LOCAL, 16'd5000, 16'd2000, 8'h01, 12);
      bv = total_valid; bd = total_drop;
      send(-1, -1, -1);
      check("big_nvalid", 32'(total_valid - bv), 32'd0);
      check("big_ndrop",  32'(total_drop - bd),  32'd1);
      check("big_len_held", 32'(bus.o_data_length), 32'd4);

      // Pixel count zero
      build(MAC_LOCAL, 16'd5000, 16'd0, 8'h00, 12);
      bv = total_valid; bd = total_drop;
      send(-1, -1, -1);
      check("zero_nvalid", 32'(total_valid - bv), 32'd0);
      check("zero_ndrop",  32'(total_drop - bd),  32'd1);

      // Carrier drops after 5 payload bytes, then a clean frame, no SOF
      build(MAC_LOCAL, 16'd5000, 16'd4, 8'h01, 12);
      bv = total_valid; bd = total_drop;
      send(50, -1, -1);
      check("cut_nvalid", 32'(total_valid - bv), 32'd5);
      check("cut_ndrop",  32'(total_drop - bd),  32'd1);
      check("cut_last",   32'(cap[(bv + 4) % 1024]), 32'h05);
      build(MAC_LOCAL, 16'd5000, 16'd4, 8'h00, 12);
      bv = total_valid; bd = total_drop; bs = total_sof;
      send(-1, -1, -1);
      check("next_nvalid", 32'(total_valid - bv), 32'd12);
      check("next_last",   32'(cap[(bv + 11) % 1024]), 32'h0C);
      check("next_nsof",   32'(total_sof - bs), 32'd0);
      check("next_ndrop",  32'(total_drop - bd), 32'd0);

      // Receive error on the third payload byte
      build(MAC_LOCAL, 16'd5000, 16'd4, 8'h01, 12);
      bv = total_valid; bd = total_drop;
      send(-1, 47, -1);
      check("er_nvalid", 32'(total_valid - bv), 32'd2);
      check("er_ndrop",  32'(total_drop - bd),  32'd1);

`ifdef RX_MAC_FILTER_EN
      build(48'h02_00_00_00_00_09, 16'd5000, 16'd4, 8'h01, 12);
      bv = total_valid; bd = total_drop;
      send(-1, -1, -1);
      check("mac_other_nvalid", 32'(total_valid - bv), 32'd0);
      check("mac_other_ndrop",  32'(total_drop - bd),  32'd1);
      build(48'hFF_FF_FF_FF_FF_FF, 16'd5000, 16'd4, 8'h01, 12);
      bv = total_valid; bd = total_drop;
      send(-1, -1, -1);
      check("mac_bcast_nvalid", 32'(total_valid - bv), 32'd12);
      check("mac_bcast_ndrop",  32'(total_drop - bd),  32'd0);
`else
      build(48'h02_00_00_00_00_09, 16'd5000, 16'd4, 8'h01, 12);
      bv = total_valid; bd = total_drop;
      send(-1, -1, -1);
      check("mac_skip_nvalid", 32'(total_valid - bv), 32'd12);
      check("mac_skip_ndrop",  32'(total_drop - bd),  32'd0);
`endif

      // Reset in the middle of the payload: rest of frame ignored
      build(MAC_LOCAL, 16'd5000, 16'd4, 8'h01, 12);
      bv = total_valid; bd = total_drop;
      send(-1, -1, 47);
      check("rstmid_nvalid", 32'(total_valid - bv), 32'd2);
      check("rstmid_ndrop",  32'(total_drop - bd),  32'd0);
      check("rstmid_len",    32'(bus.o_data_length), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
